// File: rtl/imem_burst_reader.sv
// Line-fill engine: turns a held line-fill request into BURST_LEN fixed-latency
// memory reads and returns the words in order as a valid/last beat stream.
module imem_burst_reader #(
    parameter int unsigned ADDR_WIDTH   = 22,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned BURST_LEN    = 4,
    parameter int unsigned ADDR_STEP    = 2,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset_n,
    input  logic                  i_Req_Valid,
    input  logic [ADDR_WIDTH-1:0] i_Req_Address,
    output logic                  o_Data_Valid,
    output logic                  o_Data_Last,
    output logic [DATA_WIDTH-1:0] o_Data,
    output logic                  o_Busy,
    output logic                  o_Mem_Rd_En,
    output logic [ADDR_WIDTH-1:0] o_Mem_Addr,
    input  logic                  i_Mem_Grant,
    input  logic [DATA_WIDTH-1:0] i_Mem_Rd_Data
);

    localparam int unsigned           CNT_W    = $clog2(BURST_LEN) + 1;
    localparam logic [CNT_W-1:0]      LAST_IDX = CNT_W'(BURST_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(ADDR_STEP);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE,
        ST_FLUSH
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [CNT_W-1:0]        issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]        ret_cnt_q, ret_cnt_d;
    logic [READ_LATENCY-1:0] vld_sr_q, vld_sr_d;
    logic                    accept;

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            vld_sr_q    <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            vld_sr_q    <= vld_sr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        issue_cnt_d  = issue_cnt_q;
        ret_cnt_d    = ret_cnt_q;
        accept       = 1'b0;
        o_Data_Valid = 1'b0;
        o_Data_Last  = 1'b0;
        o_Data       = '0;
        o_Busy       = (state_q != ST_IDLE);
        o_Mem_Rd_En  = 1'b0;
        o_Mem_Addr   = '0;

        case (state_q)
            ST_IDLE: begin
                if (i_Req_Valid) begin
                    base_d      = i_Req_Address;
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE, ST_DRAIN: begin
                o_Data = i_Mem_Rd_Data;
                if (state_q == ST_ISSUE) begin
                    o_Mem_Addr = base_q + STEP * ADDR_WIDTH'(issue_cnt_q);
                end
                // A dropped request aborts at once: no read, no beat, even on Last.
                if (!i_Req_Valid) begin
                    state_d = ST_FLUSH;
                end else begin
                    if (state_q == ST_ISSUE) begin
                        o_Mem_Rd_En = 1'b1;
                        accept      = i_Mem_Grant;
                        if (accept) begin
                            issue_cnt_d = issue_cnt_q + CNT_W'(1);
                            if (issue_cnt_q == LAST_IDX) begin
                                state_d = ST_DRAIN;
                            end
                        end
                    end
                    if (vld_sr_q[READ_LATENCY-1]) begin
                        o_Data_Valid = 1'b1;
                        ret_cnt_d    = ret_cnt_q + CNT_W'(1);
                        if (ret_cnt_q == LAST_IDX) begin
                            o_Data_Last = 1'b1;
                            state_d     = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_FLUSH: begin
                if (vld_sr_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        vld_sr_d = (vld_sr_q << 1) | READ_LATENCY'(accept);
    end

endmodule

// File: tb/tb_imem_burst_reader.sv
// Directed bench for imem_burst_reader: cycle tables for plain, grant-gap and
// wrap-around bursts, plus hand sequences for abort, DONE re-request and reset.
module tb_imem_burst_reader;

    logic        i_Clk = 1'b0;
    logic        i_Reset_n = 1'b0;
    logic        i_Req_Valid = 1'b0;
    logic [21:0] i_Req_Address = '0;
    logic        i_Mem_Grant = 1'b1;
    logic [31:0] i_Mem_Rd_Data;
    logic        o_Data_Valid, o_Data_Last, o_Busy, o_Mem_Rd_En;
    logic [31:0] o_Data;
    logic [21:0] o_Mem_Addr;

    int total = 0;
    int bad   = 0;

    imem_burst_reader #(
        .ADDR_WIDTH  (22),
        .DATA_WIDTH  (32),
        .BURST_LEN   (4),
        .ADDR_STEP   (2),
        .READ_LATENCY(2)
    ) dut (
        .i_Clk        (i_Clk),
        .i_Reset_n    (i_Reset_n),
        .i_Req_Valid  (i_Req_Valid),
        .i_Req_Address(i_Req_Address),
        .o_Data_Valid (o_Data_Valid),
        .o_Data_Last  (o_Data_Last),
        .o_Data       (o_Data),
        .o_Busy       (o_Busy),
        .o_Mem_Rd_En  (o_Mem_Rd_En),
        .o_Mem_Addr   (o_Mem_Addr),
        .i_Mem_Grant  (i_Mem_Grant),
        .i_Mem_Rd_Data(i_Mem_Rd_Data)
    );

    always #5 i_Clk = ~i_Clk;

    function automatic logic [31:0] mdata(input logic [21:0] a);
        return {10'h2A5, a};
    endfunction

    // Two-deep memory pipe; junk when nothing was accepted so stray data is visible.
    logic [31:0] pipe0 = 32'hBAD0_BAD0;
    logic [31:0] pipe1 = 32'hBAD0_BAD0;
    always @(posedge i_Clk) begin
        pipe0 <= (o_Mem_Rd_En && i_Mem_Grant) ? mdata(o_Mem_Addr) : 32'hBAD0_BAD0;
        pipe1 <= pipe0;
    end
    assign i_Mem_Rd_Data = pipe1;

    typedef struct {
        logic        req;
        logic [21:0] addr;
        logic        grant;
        logic        busy;
        logic        rd;
        logic [21:0] maddr;
        logic        v;
        logic        l;
        logic [31:0] d;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [21:0] a, input logic g,
                                input logic b, input logic rd, input logic [21:0] ma,
                                input logic v, input logic l, input logic [31:0] d);
        vec_t t;
        t.req = r; t.addr = a; t.grant = g; t.busy = b; t.rd = rd;
        t.maddr = ma; t.v = v; t.l = l; t.d = d;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [21:0] a, input logic g);
        i_Req_Valid   = r;
        i_Req_Address = a;
        i_Mem_Grant   = g;
        #1;
    endtask

    task automatic next_cycle();
        @(posedge i_Clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // plain burst, base 0x10, grant always high
        vecs.push_back(mk(1, 22'h10, 1, 0, 0, 22'h00, 0, 0, 32'h0));
        vecs.push_back(mk(1, 22'h10, 1, 1, 1, 22'h10, 0, 0, 32'h0));
        vecs.push_back(mk(1, 22'h10, 1, 1, 1, 22'h12, 0, 0, 32'h0));
        vecs.push_back(mk(1, 22'h10, 1, 1, 1, 22'h14, 1, 0, mdata(22'h10)));
        vecs.push_back(mk(1, 22'h10, 1, 1, 1, 22'h16, 1, 0, mdata(22'h12)));
        vecs.push_back(mk(1, 22'h10, 1, 1, 0, 22'h00, 1, 0, mdata(22'h14)));
        vecs.push_back(mk(1, 22'h10, 1, 1, 0, 22'h00, 1, 1, mdata(22'h16)));
        vecs.push_back(mk(0, 22'h10, 1, 1, 0, 22'h00, 0, 0, 32'h0));
        vecs.push_back(mk(0, 22'h00, 1, 0, 0, 22'h00, 0, 0, 32'h0));
        // grant low on cycles 2 and 3
        vecs.push_back(mk(1, 22'h10, 1, 0, 0, 22'h00, 0, 0, 32'h0));
        vecs.push_back(mk(1, 22'h10, 1, 1, 1, 22'h10, 0, 0, 32'h0));
        vecs.push_back(mk(1, 22'h10, 0, 1, 1, 22'h12, 0, 0, 32'h0));
        vecs.push_back(mk(1, 22'h10, 0, 1, 1, 22'h12, 1, 0, mdata(22'h10)));
        vecs.push_back(mk(1, 22'h10, 1, 1, 1, 22'h12, 0, 0, 32'h0));
        vecs.push_back(mk(1, 22'h10, 1, 1, 1, 22'h14, 0, 0, 32'h0));
        vecs.push_back(mk(1, 22'h10, 1, 1, 1, 22'h16, 1, 0, mdata(22'h12)));
        vecs.push_back(mk(1, 22'h10, 1, 1, 0, 22'h00, 1, 0, mdata(22'h14)));
        vecs.push_back(mk(1, 22'h10, 1, 1, 0, 22'h00, 1, 1, mdata(22'h16)));
        vecs.push_back(mk(0, 22'h10, 1, 1, 0, 22'h00, 0, 0, 32'h0));
        vecs.push_back(mk(0, 22'h00, 1, 0, 0, 22'h00, 0, 0, 32'h0));
        // address wrap-around at the top of the space
        vecs.push_back(mk(1, 22'h3FFFFC, 1, 0, 0, 22'h000000, 0, 0, 32'h0));
        vecs.push_back(mk(1, 22'h3FFFFC, 1, 1, 1, 22'h3FFFFC, 0, 0, 32'h0));
        vecs.push_back(mk(1, 22'h3FFFFC, 1, 1, 1, 22'h3FFFFE, 0, 0, 32'h0));
        vecs.push_back(mk(1, 22'h3FFFFC, 1, 1, 1, 22'h000000, 1, 0, mdata(22'h3FFFFC)));
        vecs.push_back(mk(1, 22'h3FFFFC, 1, 1, 1, 22'h000002, 1, 0, mdata(22'h3FFFFE)));
        vecs.push_back(mk(1, 22'h3FFFFC, 1, 1, 0, 22'h000000, 1, 0, mdata(22'h000000)));
        vecs.push_back(mk(1, 22'h3FFFFC, 1, 1, 0, 22'h000000, 1, 1, mdata(22'h000002)));
        vecs.push_back(mk(0, 22'h3FFFFC, 1, 1, 0, 22'h000000, 0, 0, 32'h0));
        vecs.push_back(mk(0, 22'h000000, 1, 0, 0, 22'h000000, 0, 0, 32'h0));

        // reset state
        drive(0, 22'h0, 1);
        chk("rst valid", 32'(o_Data_Valid), 32'h0);
        chk("rst last", 32'(o_Data_Last), 32'h0);
        chk("rst busy", 32'(o_Busy), 32'h0);
        chk("rst rd_en", 32'(o_Mem_Rd_En), 32'h0);
        chk("rst addr", 32'(o_Mem_Addr), 32'h0);
        chk("rst data", o_Data, 32'h0);
        next_cycle();
        next_cycle();
        i_Reset_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].req, vecs[i].addr, vecs[i].grant);
            chk($sformatf("v%0d busy", i), 32'(o_Busy), 32'(vecs[i].busy));
            chk($sformatf("v%0d rd_en", i), 32'(o_Mem_Rd_En), 32'(vecs[i].rd));
            chk($sformatf("v%0d addr", i), 32'(o_Mem_Addr), 32'(vecs[i].maddr));
            chk($sformatf("v%0d valid", i), 32'(o_Data_Valid), 32'(vecs[i].v));
            chk($sformatf("v%0d last", i), 32'(o_Data_Last), 32'(vecs[i].l));
            if (vecs[i].v) chk($sformatf("v%0d data", i), o_Data, vecs[i].d);
            next_cycle();
        end

        // abort after first beat, then a new request raised during FLUSH
        drive(1, 22'h10, 1);
        next_cycle(); next_cycle(); next_cycle();
        chk("abort c3 valid", 32'(o_Data_Valid), 32'h1);
        chk("abort c3 data", o_Data, mdata(22'h10));
        next_cycle();
        drive(0, 22'h10, 1);
        chk("abort c4 valid", 32'(o_Data_Valid), 32'h0);
        chk("abort c4 rd_en", 32'(o_Mem_Rd_En), 32'h0);
        chk("abort c4 busy", 32'(o_Busy), 32'h1);
        next_cycle();
        drive(1, 22'h40, 1);
        chk("flush c5 valid", 32'(o_Data_Valid), 32'h0);
        chk("flush c5 rd_en", 32'(o_Mem_Rd_En), 32'h0);
        chk("flush c5 busy", 32'(o_Busy), 32'h1);
        next_cycle();
        chk("flush c6 valid", 32'(o_Data_Valid), 32'h0);
        chk("flush c6 busy", 32'(o_Busy), 32'h1);
        next_cycle();
        chk("restart c7 busy", 32'(o_Busy), 32'h0);
        chk("restart c7 rd_en", 32'(o_Mem_Rd_En), 32'h0);
        next_cycle();
        chk("restart c8 rd_en", 32'(o_Mem_Rd_En), 32'h1);
        chk("restart c8 addr", 32'(o_Mem_Addr), 32'h40);
        next_cycle();
        chk("restart c9 addr", 32'(o_Mem_Addr), 32'h42);
        next_cycle();
        chk("restart c10 valid", 32'(o_Data_Valid), 32'h1);
        chk("restart c10 data", o_Data, mdata(22'h40));
        chk("restart c10 last", 32'(o_Data_Last), 32'h0);
        next_cycle(); next_cycle(); next_cycle();
        chk("restart c13 last", 32'(o_Data_Last), 32'h1);
        chk("restart c13 data", o_Data, mdata(22'h46));
        drive(0, 22'h0, 1);
        next_cycle(); next_cycle();
        chk("restart c15 busy", 32'(o_Busy), 32'h0);

        // request held through DONE with a new address
        drive(1, 22'h10, 1);
        repeat (6) next_cycle();
        chk("done c6 last", 32'(o_Data_Last), 32'h1);
        next_cycle();
        drive(1, 22'h80, 1);
        chk("done c7 busy", 32'(o_Busy), 32'h1);
        chk("done c7 rd_en", 32'(o_Mem_Rd_En), 32'h0);
        chk("done c7 valid", 32'(o_Data_Valid), 32'h0);
        next_cycle();
        chk("done c8 busy", 32'(o_Busy), 32'h0);
        chk("done c8 rd_en", 32'(o_Mem_Rd_En), 32'h0);
        next_cycle();
        chk("done c9 rd_en", 32'(o_Mem_Rd_En), 32'h1);
        chk("done c9 addr", 32'(o_Mem_Addr), 32'h80);
        next_cycle();
        drive(0, 22'h0, 1);
        next_cycle(); next_cycle(); next_cycle();
        chk("done c13 busy", 32'(o_Busy), 32'h0);

        // reset pulsed mid-DRAIN
        drive(1, 22'h10, 1);
        repeat (5) next_cycle();
        chk("rstm c5 valid", 32'(o_Data_Valid), 32'h1);
        chk("rstm c5 data", o_Data, mdata(22'h14));
        i_Reset_n = 1'b0;
        drive(0, 22'h10, 1);
        chk("rstm valid", 32'(o_Data_Valid), 32'h0);
        chk("rstm last", 32'(o_Data_Last), 32'h0);
        chk("rstm busy", 32'(o_Busy), 32'h0);
        chk("rstm rd_en", 32'(o_Mem_Rd_En), 32'h0);
        chk("rstm addr", 32'(o_Mem_Addr), 32'h0);
        chk("rstm data", o_Data, 32'h0);
        next_cycle();
        i_Reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rstm post%0d valid", k), 32'(o_Data_Valid), 32'h0);
            chk($sformatf("rstm post%0d busy", k), 32'(o_Busy), 32'h0);
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_burst_reader.md
# imem_burst_reader

Line-fill engine between the instruction cache's miss port and the shared instruction memory. It accepts a held-level line-fill request, issues BURST_LEN word reads to a fixed-latency memory through a grant-arbitrated port, and returns the words in order as a valid/last beat stream. That stream drives the cache's i_MEM_Valid / i_MEM_Last / i_MEM_Data inputs.

## Interface
- ADDR_WIDTH, 22: request and memory address width.
- DATA_WIDTH, 32: beat width.
- BURST_LEN, 4: beats per line fill (power of two, 2..16).
- ADDR_STEP, 2: address increment between consecutive beats.
- READ_LATENCY, 2: cycles from an accepted read to its data on i_Mem_Rd_Data (1..8).

Ports:
- i_Clk  in  1  clock; all state changes on rising edge.
- i_Reset_n  in  1  asynchronous, active-low reset.
- i_Req_Valid  in  1  line-fill request, held high until the Last beat is seen.
- i_Req_Address  in  ADDR_WIDTH  line base address, stable while i_Req_Valid is high.
- o_Data_Valid  out  1  beat valid.
- o_Data_Last  out  1  final beat of the burst (qualified by o_Data_Valid).
- o_Data  out  DATA_WIDTH  beat data.
- o_Busy  out  1  high in any state other than IDLE.
- o_Mem_Rd_En  out  1  read request to memory.
- o_Mem_Addr  out  ADDR_WIDTH  read address.
- i_Mem_Grant  in  1  arbiter grant; a read is accepted in a cycle with o_Mem_Rd_En && i_Mem_Grant.
- i_Mem_Rd_Data  in  DATA_WIDTH  read data, valid READ_LATENCY cycles after acceptance.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE, FLUSH.
- IDLE: when i_Req_Valid is high, latch i_Req_Address into the base register, clear the issue and return counters, and go to ISSUE.
- ISSUE:
  - o_Mem_Rd_En = i_Req_Valid; o_Mem_Addr = base + issue_cnt*ADDR_STEP, truncated to ADDR_WIDTH (wrap-around is allowed).
  - Each accepted read increments issue_cnt. When the BURST_LEN-th read is accepted, go to DRAIN.
  - If i_Mem_Grant is low, the request is held and the address is unchanged.
- In-flight tracking: a READ_LATENCY-deep valid shift register. Bit 0 is set in any cycle a read is accepted.
- Beat output, in ISSUE and DRAIN:
  - o_Data_Valid = the shift register's output stage, qualified by i_Req_Valid.
  - o_Data = i_Mem_Rd_Data, passed through combinationally.
  - Each beat increments ret_cnt. o_Data_Last = o_Data_Valid && ret_cnt == BURST_LEN-1.
- Last beat emitted: go to DONE.
- DONE: lasts exactly one cycle and ignores i_Req_Valid, because the cache drops its request one cycle after Last. Then go to IDLE.
- Abort: i_Req_Valid low while in ISSUE or DRAIN:
  - Stop issuing, suppress all beats, go to FLUSH.
  - FLUSH: stay until the shift register is empty, then go to IDLE.
  - A request present in FLUSH is not latched until IDLE.
- Counter widths: issue_cnt and ret_cnt are $clog2(BURST_LEN)+1 bits. No counter may exceed BURST_LEN.
- Outside ISSUE: o_Mem_Rd_En = 0 and o_Mem_Addr = 0.
- Outside ISSUE/DRAIN: o_Data_Valid = 0 and o_Data_Last = 0.

## Timing
- Reset: asynchronous. State = IDLE, counters = 0, shift register = 0.
  - All outputs low: o_Data_Valid, o_Data_Last, o_Busy, o_Mem_Rd_En, o_Mem_Addr = 0, o_Data = 0.
  - Reset mid-burst drops all in-flight reads; their returning data is never flagged valid.
- Cycle 0: request seen in IDLE. Cycle 1: first read issued, o_Busy high.
- First beat arrives at cycle 1+READ_LATENCY with continuous grant.
- Minimum burst, back-to-back: beats on cycles 1+READ_LATENCY through BURST_LEN+READ_LATENCY. Last is on the final beat, DONE is the next cycle, and IDLE the cycle after.
- Default parameters: beats on cycles 3, 4, 5, 6; Last on 6; DONE on 7; IDLE on 8; earliest next latch on 8.
- Grant gaps: each low-grant cycle delays all later beats by one cycle. Beats stay in order and are never duplicated.
- In-flight reads never exceed READ_LATENCY, so no data buffering is required.
- Simultaneous events:
  - Abort in the same cycle as a valid beat: the beat is suppressed.
  - Abort in the same cycle as Last: the beat is suppressed and the state goes to FLUSH.

## Test plan
- Default parameters, base 0x000010, grant always high:
  - o_Mem_Addr = 0x10, 0x12, 0x14, 0x16 on cycles 1–4.
  - o_Data_Valid on cycles 3–6 with the memory model's data; o_Data_Last only on cycle 6.
  - o_Busy low on cycle 8.
- Same request with grant low on cycles 2 and 3: address 0x12 is held for 3 cycles, beats land on cycles 3, 6, 7, 8, and Last is on cycle 8.
- Base 0x3FFFFC with ADDR_WIDTH=22: addresses 0x3FFFFC, 0x3FFFFE, 0x000000, 0x000002 (wrap-around).
- Request drops after beat 1: no further o_Data_Valid. Reads still in flight drain in FLUSH. A new request at 0x40 then restarts cleanly with address 0x40 first.
- Request held high through DONE, with a new address presented in DONE: no re-latch in DONE; a new burst starts only from IDLE.
- i_Reset_n pulsed low mid-DRAIN: all outputs are 0 immediately. No valid beat appears afterward, even though memory data returns.
